// File: rtl/io_write_arbiter.sv
// Arbitrates the IO manager's single light/tube write port between the CPU store
// path (requester 0) and the UART debug monitor (requester 1), with registered outputs.
module io_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        iCpuClock,
    input  logic        iCpuReset,
    input  logic        iCpuReq,
    input  logic        iCpuTarget,
    input  logic [1:0]  iCpuAddr,
    input  logic [15:0] iCpuData,
    output logic        oCpuAck,
    input  logic        iUartReq,
    input  logic        iUartTarget,
    input  logic [1:0]  iUartAddr,
    input  logic [15:0] iUartData,
    output logic        oUartAck,
    input  logic        iUartLock,
    output logic        oDoLedWrite,
    output logic [1:0]  oLightAddress,
    output logic [15:0] oLightData,
    output logic        oDoTubeWrite,
    output logic [1:0]  oTubeAddress,
    output logic [15:0] oTubeData,
    output logic        oLastOwner
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic        cpu_ack_q,    cpu_ack_d;
    logic        uart_ack_q,   uart_ack_d;
    logic        led_we_q,     led_we_d;
    logic [1:0]  light_addr_q, light_addr_d;
    logic [15:0] light_data_q, light_data_d;
    logic        tube_we_q,    tube_we_d;
    logic [1:0]  tube_addr_q,  tube_addr_d;
    logic [15:0] tube_data_q,  tube_data_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;

    logic        cpu_elig_s;
    logic        uart_elig_s;
    logic        grant_cpu_s;
    logic        grant_uart_s;
    logic        grant_any_s;
    logic        win_target_s;
    logic [1:0]  win_addr_s;
    logic [15:0] win_data_s;

    // Eligibility and winner selection; a requester whose ack is high sits out one edge.
    always_comb begin
        cpu_elig_s   = iCpuReq & ~cpu_ack_q & ~iUartLock;
        uart_elig_s  = iUartReq & ~uart_ack_q;
        grant_cpu_s  = 1'b0;
        grant_uart_s = 1'b0;
        if (cpu_elig_s && uart_elig_s) begin
            if (starve_cnt_q == LIMIT) begin
                grant_uart_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b1;
            end
        end else if (cpu_elig_s) begin
            grant_cpu_s = 1'b1;
        end else if (uart_elig_s) begin
            grant_uart_s = 1'b1;
        end else begin
            grant_cpu_s  = 1'b0;
            grant_uart_s = 1'b0;
        end
        grant_any_s = grant_cpu_s | grant_uart_s;
    end

    // Payload of the winning requester.
    always_comb begin
        if (grant_uart_s) begin
            win_target_s = iUartTarget;
            win_addr_s   = iUartAddr;
            win_data_s   = iUartData;
        end else begin
            win_target_s = iCpuTarget;
            win_addr_s   = iCpuAddr;
            win_data_s   = iCpuData;
        end
    end

    // Next-state for acks, strobes, address/data holding registers and owner.
    always_comb begin
        cpu_ack_d    = grant_cpu_s;
        uart_ack_d   = grant_uart_s;
        led_we_d     = grant_any_s & ~win_target_s;
        tube_we_d    = grant_any_s &  win_target_s;
        light_addr_d = light_addr_q;
        light_data_d = light_data_q;
        tube_addr_d  = tube_addr_q;
        tube_data_d  = tube_data_q;
        last_owner_d = last_owner_q;
        if (grant_any_s) begin
            last_owner_d = grant_uart_s;
            if (win_target_s) begin
                tube_addr_d = win_addr_s;
                tube_data_d = win_data_s;
            end else begin
                light_addr_d = win_addr_s;
                light_data_d = win_data_s;
            end
        end else begin
            last_owner_d = last_owner_q;
        end
    end

    // Starvation counter: counts CPU wins over a waiting UART, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!iUartReq || grant_uart_s) begin
            starve_cnt_d = 8'd0;
        end else if (uart_elig_s && grant_cpu_s && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // State registers; reset also cancels any in-flight strobe or ack.
    always_ff @(posedge iCpuClock or posedge iCpuReset) begin
        if (iCpuReset) begin
            cpu_ack_q    <= 1'b0;
            uart_ack_q   <= 1'b0;
            led_we_q     <= 1'b0;
            light_addr_q <= 2'd0;
            light_data_q <= 16'd0;
            tube_we_q    <= 1'b0;
            tube_addr_q  <= 2'd0;
            tube_data_q  <= 16'd0;
            last_owner_q <= 1'b0;
            starve_cnt_q <= 8'd0;
        end else begin
            cpu_ack_q    <= cpu_ack_d;
            uart_ack_q   <= uart_ack_d;
            led_we_q     <= led_we_d;
            light_addr_q <= light_addr_d;
            light_data_q <= light_data_d;
            tube_we_q    <= tube_we_d;
            tube_addr_q  <= tube_addr_d;
            tube_data_q  <= tube_data_d;
            last_owner_q <= last_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign oCpuAck       = cpu_ack_q;
    assign oUartAck      = uart_ack_q;
    assign oDoLedWrite   = led_we_q;
    assign oLightAddress = light_addr_q;
    assign oLightData    = light_data_q;
    assign oDoTubeWrite  = tube_we_q;
    assign oTubeAddress  = tube_addr_q;
    assign oTubeData     = tube_data_q;
    assign oLastOwner    = last_owner_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Self-checking bench for io_write_arbiter: directed scenarios plus randomized
// requester traffic compared against a rule-level reference model.
module tb_io_write_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_tgt = 1'b0;
    logic [1:0]  cpu_addr = 2'd0;
    logic [15:0] cpu_data = 16'd0;
    logic        uart_req = 1'b0, uart_tgt = 1'b0;
    logic [1:0]  uart_addr = 2'd0;
    logic [15:0] uart_data = 16'd0;
    logic        lock = 1'b0;
    logic        cpu_ack, uart_ack, led_we, tube_we, last_owner;
    logic [1:0]  light_addr, tube_addr;
    logic [15:0] light_data, tube_data;

    int errors = 0;
    int checks = 0;

    // Reference model state, plain integers.
    int m_cpu_ack, m_uart_ack, m_led, m_tube, m_owner, m_cnt;
    int m_laddr, m_ldata, m_taddr, m_tdata;

    io_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .iCpuClock(clk), .iCpuReset(rst),
        .iCpuReq(cpu_req), .iCpuTarget(cpu_tgt), .iCpuAddr(cpu_addr), .iCpuData(cpu_data),
        .oCpuAck(cpu_ack),
        .iUartReq(uart_req), .iUartTarget(uart_tgt), .iUartAddr(uart_addr), .iUartData(uart_data),
        .oUartAck(uart_ack), .iUartLock(lock),
        .oDoLedWrite(led_we), .oLightAddress(light_addr), .oLightData(light_data),
        .oDoTubeWrite(tube_we), .oTubeAddress(tube_addr), .oTubeData(tube_data),
        .oLastOwner(last_owner)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cpu_ack = 0; m_uart_ack = 0; m_led = 0; m_tube = 0; m_owner = 0; m_cnt = 0;
        m_laddr = 0; m_ldata = 0; m_taddr = 0; m_tdata = 0;
    endtask

    // Apply the arbitration rules to the inputs that the coming edge will sample.
    task automatic model_edge();
        int winner, tgt, addr, data;
        bit ce, ue;
        ce = cpu_req && (m_cpu_ack == 0) && !lock;
        ue = uart_req && (m_uart_ack == 0);
        if (ce && ue) winner = (m_cnt == LIMIT) ? 1 : 0;
        else if (ce)  winner = 0;
        else if (ue)  winner = 1;
        else          winner = -1;
        if (!uart_req || winner == 1) m_cnt = 0;
        else if (ue && winner == 0 && m_cnt < LIMIT) m_cnt = m_cnt + 1;
        m_cpu_ack  = (winner == 0);
        m_uart_ack = (winner == 1);
        m_led = 0;
        m_tube = 0;
        if (winner >= 0) begin
            tgt  = (winner == 1) ? int'(uart_tgt)  : int'(cpu_tgt);
            addr = (winner == 1) ? int'(uart_addr) : int'(cpu_addr);
            data = (winner == 1) ? int'(uart_data) : int'(cpu_data);
            m_owner = winner;
            if (tgt == 0) begin m_led = 1;  m_laddr = addr; m_ldata = data; end
            else          begin m_tube = 1; m_taddr = addr; m_tdata = data; end
        end
    endtask

    task automatic compare_all();
        check_val("cpu_ack", cpu_ack, m_cpu_ack);
        check_val("uart_ack", uart_ack, m_uart_ack);
        check_val("led_we", led_we, m_led);
        check_val("tube_we", tube_we, m_tube);
        check_val("light_addr", light_addr, m_laddr);
        check_val("light_data", light_data, m_ldata);
        check_val("tube_addr", tube_addr, m_taddr);
        check_val("tube_data", tube_data, m_tdata);
        check_val("last_owner", last_owner, m_owner);
    endtask

    // One clock: predict, advance, sample 1 time unit after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Async reset pulse mid-cycle; requests stay asserted.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("rst_cpu_ack", cpu_ack, 0);
        check_val("rst_uart_ack", uart_ack, 0);
        check_val("rst_led_we", led_we, 0);
        check_val("rst_tube_we", tube_we, 0);
        check_val("rst_owner", last_owner, 0);
        check_val("rst_tube_data", tube_data, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int prev_ack;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // CPU light write
        cpu_req = 1'b1; cpu_tgt = 1'b0; cpu_addr = 2'd2; cpu_data = 16'h00A5;
        cycle();
        check_val("d1_led_we", led_we, 1);
        check_val("d1_light_data", light_data, 16'h00A5);
        cpu_req = 1'b0;
        cycle();
        check_val("d1_hold", light_data, 16'h00A5);
        check_val("d1_led_off", led_we, 0);

        // Lock stalls the CPU
        lock = 1'b1; cpu_req = 1'b1; cpu_data = 16'h1234;
        repeat (20) begin
            cycle();
            check_val("lock_ack", cpu_ack, 0);
        end
        lock = 1'b0;
        cycle();
        check_val("unlock_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        cycle();

        // Held CPU request: acks never on consecutive cycles
        cpu_req = 1'b1; prev_ack = 0;
        repeat (6) begin
            cycle();
            check_val("no_back2back", int'(cpu_ack) & prev_ack, 0);
            prev_ack = cpu_ack;
        end
        cpu_req = 1'b0;
        cycle();

        // UART tube write
        uart_req = 1'b1; uart_tgt = 1'b1; uart_addr = 2'd3; uart_data = 16'hBEEF;
        cycle();
        check_val("u_tube_we", tube_we, 1);
        check_val("u_tube_addr", tube_addr, 3);
        check_val("u_tube_data", tube_data, 16'hBEEF);
        check_val("u_owner", last_owner, 1);
        uart_req = 1'b0;
        cycle();

        // Async reset during a tube strobe
        cpu_req = 1'b1; cpu_tgt = 1'b1; cpu_data = 16'h5A5A;
        cycle();
        check_val("pre_rst_tube_we", tube_we, 1);
        async_reset();
        cycle();
        check_val("rearb_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_req || cpu_ack) begin
                cpu_req  = ($urandom_range(0, 3) != 0);
                cpu_tgt  = 1'($urandom);
                cpu_addr = 2'($urandom);
                cpu_data = 16'($urandom);
            end
            if (!uart_req || uart_ack) begin
                uart_req  = ($urandom_range(0, 3) != 0);
                uart_tgt  = 1'($urandom);
                uart_addr = 2'($urandom);
                uart_data = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) lock = ~lock;
            cycle();
            check_val("one_strobe", int'(led_we) & int'(tube_we), 0);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
